// File: rtl/sram_controller_pkg.sv
// Shared types and defaults for the SRAM controller blocks.
// Check-bit store state encoding and default geometry.
package sram_controller_pkg;

  typedef enum logic {
    CS_INIT,
    CS_READY
  } check_store_state_e;

  localparam int SRAM_DEPTH   = 256;
  localparam int SRAM_CHECK_W = 1;

endpackage

// File: rtl/sram_controller_sat_counter.sv
// Saturating event counter with synchronous clear.
// A clear coinciding with an event leaves a count of one.
module sram_controller_sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] count
);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (clr) begin
      count <= inc ? W'(1) : '0;
    end else if (inc && (count != '1)) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/sram_controller_check_store.sv
// Check-bit store: RAM-inferable array, sequential init engine,
// registered read/compare port and saturating mismatch counter.
module sram_controller_check_store
  import sram_controller_pkg::*;
#(
  parameter int DEPTH   = SRAM_DEPTH,
  parameter int ADDR_W  = $clog2(DEPTH),
  parameter int CHECK_W = SRAM_CHECK_W,
  parameter int CNT_W   = 16
) (
  input  logic               clk,
  input  logic               reset_n,
  output logic               ready,
  input  logic               init_req,
  input  logic               wr_en,
  input  logic [ADDR_W-1:0]  wr_addr,
  input  logic [CHECK_W-1:0] wr_check,
  input  logic               rd_en,
  input  logic [ADDR_W-1:0]  rd_addr,
  input  logic [CHECK_W-1:0] rd_expected,
  output logic               rd_valid,
  output logic [CHECK_W-1:0] rd_check,
  output logic               rd_mismatch,
  input  logic               err_clr,
  output logic [CNT_W-1:0]   err_count
);

  check_store_state_e state, state_d;
  logic [ADDR_W-1:0]  init_ptr, ptr_d;

  logic [CHECK_W-1:0] mem [DEPTH];
  logic               mem_we;
  logic [ADDR_W-1:0]  mem_addr;
  logic [CHECK_W-1:0] mem_data;

  logic               wr_go;
  logic               rd_go;
  logic               bypass;
  logic [CHECK_W-1:0] exp_q;

  assign ready  = (state == CS_READY);
  // A write racing init_req is dropped: INIT zeroes it anyway.
  assign wr_go  = ready && wr_en && !init_req;
  assign rd_go  = ready && rd_en;
  assign bypass = wr_go && (wr_addr == rd_addr);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= CS_INIT;
      init_ptr <= '0;
    end else begin
      state    <= state_d;
      init_ptr <= ptr_d;
    end
  end

  always_comb begin
    state_d = state;
    ptr_d   = init_ptr;
    unique case (state)
      CS_INIT: begin
        ptr_d = init_ptr + 1'b1;
        if (init_ptr == ADDR_W'(DEPTH - 1)) begin
          state_d = CS_READY;
        end
      end
      CS_READY: begin
        if (init_req) begin
          state_d = CS_INIT;
          ptr_d   = '0;
        end
      end
      default: state_d = CS_INIT;
    endcase
  end

  always_comb begin
    mem_we   = 1'b0;
    mem_addr = wr_addr;
    mem_data = wr_check;
    if (state == CS_INIT) begin
      mem_we   = 1'b1;
      mem_addr = init_ptr;
      mem_data = '0;
    end else if (wr_go) begin
      mem_we = 1'b1;
    end
  end

  // No reset on the array so it maps onto RAM.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_addr] <= mem_data;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_valid <= 1'b0;
      rd_check <= '0;
      exp_q    <= '0;
    end else begin
      rd_valid <= rd_go;
      if (rd_go) begin
        rd_check <= bypass ? wr_check : mem[rd_addr];
        exp_q    <= rd_expected;
      end
    end
  end

  assign rd_mismatch = rd_valid && (rd_check != exp_q);

  sram_controller_sat_counter #(
    .W(CNT_W)
  ) u_err_cnt (
    .clk    (clk),
    .reset_n(reset_n),
    .inc    (rd_mismatch),
    .clr    (err_clr),
    .count  (err_count)
  );

endmodule

// File: tb/tb_sram_controller_check_store.sv
// Bench for the check-bit store: two geometries against a
// behavioural model of store contents, init window and counter.
module tb_sram_controller_check_store;

  localparam int N = 2;

  int dep  [N] = '{256, 16};
  int cmax [N] = '{65535, 3};
  logic [3:0] msk [N] = '{4'h1, 4'hF};

  logic clk = 1'b0;
  logic reset_n = 1'b0;

  logic       init_req    [N];
  logic       wr_en       [N];
  logic [7:0] wr_addr     [N];
  logic [3:0] wr_check    [N];
  logic       rd_en       [N];
  logic [7:0] rd_addr     [N];
  logic [3:0] rd_expected [N];
  logic       err_clr     [N];

  logic        rdy0, rv0, rm0;
  logic [0:0]  rc0;
  logic [15:0] ec0;
  logic        rdy1, rv1, rm1;
  logic [3:0]  rc1;
  logic [1:0]  ec1;

  int checks = 0;
  int errors = 0;

  bit         m_ready [N];
  int         left    [N];
  logic [3:0] mem     [N][256];
  logic       ev      [N];
  logic       emis    [N];
  logic [3:0] echk    [N];
  int         ecnt    [N];

  always #5 clk = ~clk;

  sram_controller_check_store #(
    .DEPTH(256), .CHECK_W(1), .CNT_W(16)
  ) dut0 (
    .clk(clk), .reset_n(reset_n), .ready(rdy0),
    .init_req(init_req[0]), .wr_en(wr_en[0]),
    .wr_addr(wr_addr[0]), .wr_check(wr_check[0][0:0]),
    .rd_en(rd_en[0]), .rd_addr(rd_addr[0]),
    .rd_expected(rd_expected[0][0:0]),
    .rd_valid(rv0), .rd_check(rc0), .rd_mismatch(rm0),
    .err_clr(err_clr[0]), .err_count(ec0)
  );

  sram_controller_check_store #(
    .DEPTH(16), .CHECK_W(4), .CNT_W(2)
  ) dut1 (
    .clk(clk), .reset_n(reset_n), .ready(rdy1),
    .init_req(init_req[1]), .wr_en(wr_en[1]),
    .wr_addr(wr_addr[1][3:0]), .wr_check(wr_check[1]),
    .rd_en(rd_en[1]), .rd_addr(rd_addr[1][3:0]),
    .rd_expected(rd_expected[1]),
    .rd_valid(rv1), .rd_check(rc1), .rd_mismatch(rm1),
    .err_clr(err_clr[1]), .err_count(ec1)
  );

  task automatic chk(string tag, int i,
                     logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s[%0d] at %0t: observed %0h expected %0h",
             tag, i, $time, obs, exp);
    end
  endtask

  task automatic idle(int i);
    init_req[i]    = 1'b0;
    wr_en[i]       = 1'b0;
    wr_addr[i]     = '0;
    wr_check[i]    = '0;
    rd_en[i]       = 1'b0;
    rd_addr[i]     = '0;
    rd_expected[i] = '0;
    err_clr[i]     = 1'b0;
  endtask

  task automatic drive(int i, bit we, int wa, logic [3:0] wc,
                       bit re, int ra, logic [3:0] rx);
    wr_en[i]       = we;
    wr_addr[i]     = 8'(wa % dep[i]);
    wr_check[i]    = wc & msk[i];
    rd_en[i]       = re;
    rd_addr[i]     = 8'(ra % dep[i]);
    rd_expected[i] = rx & msk[i];
  endtask

  task automatic model_edge();
    logic inc, wgo, rgo;
    int wa, ra;
    for (int i = 0; i < N; i++) begin
      inc = ev[i] && emis[i];
      if (err_clr[i]) ecnt[i] = inc ? 1 : 0;
      else if (inc && ecnt[i] < cmax[i]) ecnt[i]++;
      wa  = int'(wr_addr[i]) % dep[i];
      ra  = int'(rd_addr[i]) % dep[i];
      wgo = m_ready[i] && wr_en[i] && !init_req[i];
      rgo = m_ready[i] && rd_en[i];
      ev[i]   = rgo;
      emis[i] = 1'b0;
      if (rgo) begin
        echk[i] = (wgo && wa == ra) ? wr_check[i] : mem[i][ra];
        emis[i] = (echk[i] != rd_expected[i]);
      end
      if (wgo) mem[i][wa] = wr_check[i];
      if (m_ready[i] && init_req[i]) begin
        m_ready[i] = 1'b0;
        left[i]    = dep[i];
        for (int a = 0; a < 256; a++) mem[i][a] = '0;
      end else if (!m_ready[i]) begin
        left[i]--;
        if (left[i] == 0) m_ready[i] = 1'b1;
      end
    end
  endtask

  task automatic check_all();
    chk("ready", 0, 32'(rdy0), 32'(m_ready[0]));
    chk("rd_valid", 0, 32'(rv0), 32'(ev[0]));
    chk("err_count", 0, 32'(ec0), 32'(ecnt[0]));
    if (ev[0]) begin
      chk("rd_check", 0, 32'(rc0), 32'(echk[0]));
      chk("rd_mismatch", 0, 32'(rm0), 32'(emis[0]));
    end
    chk("ready", 1, 32'(rdy1), 32'(m_ready[1]));
    chk("rd_valid", 1, 32'(rv1), 32'(ev[1]));
    chk("err_count", 1, 32'(ec1), 32'(ecnt[1]));
    if (ev[1]) begin
      chk("rd_check", 1, 32'(rc1), 32'(echk[1]));
      chk("rd_mismatch", 1, 32'(rm1), 32'(emis[1]));
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    #1;
    for (int i = 0; i < N; i++) begin
      idle(i);
      m_ready[i] = 1'b0;
      left[i]    = dep[i];
      ev[i]      = 1'b0;
      emis[i]    = 1'b0;
      echk[i]    = '0;
      ecnt[i]    = 0;
      for (int a = 0; a < 256; a++) mem[i][a] = '0;
    end
    check_all();
    chk("rst_check", 0, 32'(rc0), 32'd0);
    chk("rst_check", 1, 32'(rc1), 32'd0);
    chk("rst_mis", 0, 32'(rm0), 32'd0);
    chk("rst_mis", 1, 32'(rm1), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  initial begin
    for (int i = 0; i < N; i++) idle(i);
    do_reset();
    repeat (260) tick();

    for (int a = 0; a < 256; a++) begin
      drive(0, 0, 0, 0, 1, a, 0);
      drive(1, 0, 0, 0, 1, a, 0);
      tick();
    end
    idle(0); idle(1);
    tick();

    drive(0, 1, 'h2A, 1, 0, 0, 0);
    tick();
    drive(0, 0, 0, 0, 1, 'h2A, 0);
    tick();
    idle(0);
    tick();
    tick();

    drive(0, 1, 'h10, 1, 1, 'h10, 1);
    tick();
    drive(0, 1, 'h11, 1, 1, 'h12, 0);
    tick();
    drive(0, 0, 0, 0, 1, 'h11, 1);
    tick();
    idle(0);
    tick();

    drive(1, 1, 3, 4'hA, 0, 0, 0);
    tick();
    repeat (5) begin
      drive(1, 0, 0, 0, 1, 3, 4'h5);
      tick();
    end
    idle(1);
    tick();
    tick();
    drive(1, 0, 0, 0, 1, 3, 4'h5);
    tick();
    idle(1);
    err_clr[1] = 1'b1;
    tick();
    idle(1);
    tick();

    repeat (300) begin
      for (int i = 0; i < N; i++) begin
        int wa, ra;
        wa = $urandom_range(0, dep[i] - 1);
        ra = ($urandom_range(0, 1) == 1) ? wa
             : $urandom_range(0, dep[i] - 1);
        drive(i, $urandom_range(0, 1) == 1, wa, 4'($urandom),
              $urandom_range(0, 1) == 1, ra,
              ($urandom_range(0, 1) == 1) ? 4'($urandom) : 4'h0);
        init_req[i] = ($urandom_range(0, 63) == 0);
        err_clr[i]  = ($urandom_range(0, 31) == 0);
      end
      tick();
    end
    idle(0); idle(1);
    repeat (260) tick();

    drive(0, 1, 'hFF, 1, 0, 0, 0);
    tick();
    idle(0);
    init_req[0] = 1'b1;
    drive(0, 0, 0, 0, 1, 'h05, 1);
    tick();
    idle(0);
    repeat (256) begin
      drive(0, $urandom_range(0, 1) == 1, $urandom_range(0, 255), 1,
            $urandom_range(0, 1) == 1, $urandom_range(0, 255), 1);
      tick();
    end
    drive(0, 0, 0, 0, 1, 'hFF, 0);
    tick();
    idle(0);
    tick();

    do_reset();
    repeat (100) tick();
    do_reset();
    repeat (258) tick();
    drive(0, 0, 0, 0, 1, 7, 1);
    drive(1, 0, 0, 0, 1, 7, 4'h9);
    tick();
    do_reset();
    repeat (20) begin
      drive(1, 1, $urandom_range(0, 15), 4'($urandom),
            1, $urandom_range(0, 15), 4'($urandom));
      tick();
    end
    idle(1);
    repeat (240) tick();
    for (int a = 0; a < 16; a++) begin
      drive(1, 1, a, 4'(a ^ 4'h6), 1, a, 4'(a));
      tick();
    end
    idle(1);
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
